// File: rtl/alu_issue_ctrl_if.sv
// Handshake bundle for the ALU issue stage: instruction in, result out.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [1:0]        out_rd;
    logic              out_zero;
    logic              out_illegal;

    modport master (
        output instr_valid, instr, out_ready,
        input  instr_ready, out_valid, out_result,
        input  out_rd, out_zero, out_illegal
    );

    modport slave (
        input  instr_valid, instr, out_ready,
        output instr_ready, out_valid, out_result,
        output out_rd, out_zero, out_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage around an external combinational ALU.
// Three-state sequencer: IDLE accept, EXEC capture/writeback, DONE drain.
module alu_issue_ctrl #(
    parameter int                DATA_W    = 8,
    parameter int                REG_CNT   = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        rd;
    logic [DATA_W-1:0] rf [REG_CNT];

    logic [1:0] ra;
    logic [1:0] rb;
    logic       imm_sel;
    logic       accept;
    logic       illegal;

    assign ra      = bus.instr[10:9];
    assign rb      = bus.instr[1:0];
    assign imm_sel = bus.instr[8];

    assign bus.instr_ready = (state == IDLE);
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign illegal         = alu_opcode[2] && alu_opcode[1];

    // Same-cycle writes land at the edge, so this naturally returns the old value.
    assign dbg_data = rf[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rd              <= '0;
            alu_opcode      <= '0;
            alu_a           <= '0;
            alu_b           <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_result  <= '0;
            bus.out_rd      <= '0;
            bus.out_zero    <= 1'b0;
            bus.out_illegal <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) begin
                rf[i] <= RESET_VAL;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_opcode <= bus.instr[15:13];
                        alu_a      <= rf[ra];
                        alu_b      <= imm_sel ? DATA_W'(bus.instr[7:0])
                                              : rf[rb];
                        rd         <= bus.instr[12:11];
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    bus.out_result  <= alu_result;
                    bus.out_rd      <= rd;
                    bus.out_zero    <= (alu_result == '0);
                    bus.out_illegal <= illegal;
                    bus.out_valid   <= 1'b1;
                    if (!illegal) begin
                        rf[rd] <= alu_result;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a model ALU and result scoreboard.
module tb_alu_issue_ctrl;
    typedef struct packed {
        logic [7:0] result;
        logic [1:0] rd;
        logic       zero;
        logic       illegal;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic [1:0] dbg_addr = 2'd0;
    logic [7:0] dbg_data;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    logic [7:0] mrf [4];

    alu_issue_ctrl_if #(.DATA_W(8)) bus ();

    alu_issue_ctrl #(
        .DATA_W(8),
        .REG_CNT(4),
        .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .alu_opcode(alu_opcode),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_result(alu_result),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(
        input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << 1;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_opcode, alu_a, alu_b);

    function automatic logic [15:0] enc(
        input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
        input logic isel, input logic [7:0] imm);
        return {op, rd, ra, isel, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept monitor: inputs change only at posedge+1, so negedge sees the edge-to-be.
    always @(negedge clk) begin
        if (rst_n && bus.instr_valid && bus.instr_ready) begin
            logic [2:0] op;
            logic [1:0] rd;
            logic [7:0] a;
            logic [7:0] b;
            exp_t e;
            op = bus.instr[15:13];
            rd = bus.instr[12:11];
            a  = mrf[bus.instr[10:9]];
            b  = bus.instr[8] ? bus.instr[7:0] : mrf[bus.instr[1:0]];
            e.result  = alu_fn(op, a, b);
            e.rd      = rd;
            e.zero    = (e.result == 8'h00);
            e.illegal = (op == 3'b110) || (op == 3'b111);
            if (!e.illegal) mrf[rd] = e.result;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                chk("out_result", bus.out_result, q[0].result);
                chk("out_rd", bus.out_rd, q[0].rd);
                chk("out_zero", bus.out_zero, q[0].zero);
                chk("out_illegal", bus.out_illegal, q[0].illegal);
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
    endtask

    task automatic put(input logic [15:0] w);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.instr = w;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.instr_ready && !bus.out_valid && q.size() == 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic dbg_chk(input logic [1:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk("dbg_data", dbg_data, exp);
    endtask

    initial begin
        int acc;
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0000;
        bus.out_ready = 1'b1;
        do_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset: populate rf, then abandon an instruction mid-EXEC.
        put(enc(3'd0, 2'd3, 2'd0, 1'b1, 8'h07));
        wait_idle();
        dbg_chk(2'd3, 8'h07);
        put(enc(3'd0, 2'd2, 2'd3, 1'b1, 8'h01));
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_instr_ready", bus.instr_ready, 1'b1);
        chk("rst_out_valid2", bus.out_valid, 1'b0);
        for (int i = 0; i < 4; i++) dbg_chk(2'(i), 8'h00);

        // Immediate ADD with latency check, then wrap-around.
        put(enc(3'd0, 2'd1, 2'd0, 1'b1, 8'h05));
        @(negedge clk);
        chk("lat_exec_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("lat_done_valid", bus.out_valid, 1'b1);
        chk("lat_rf_write", dbg_data, (dbg_addr == 2'd1) ? 8'h05 : mrf[dbg_addr]);
        wait_idle();
        dbg_chk(2'd1, 8'h05);
        put(enc(3'd0, 2'd1, 2'd1, 1'b1, 8'hFF));
        wait_idle();
        dbg_chk(2'd1, 8'h04);

        // Register SUB producing zero.
        put(enc(3'd0, 2'd0, 2'd0, 1'b1, 8'h11));
        put(enc(3'd0, 2'd2, 2'd1, 1'b1, 8'h38));
        put(enc(3'd0, 2'd3, 2'd1, 1'b1, 8'h38));
        wait_idle();
        dbg_chk(2'd0, 8'h11);
        dbg_chk(2'd2, 8'h3C);
        put(enc(3'd1, 2'd0, 2'd2, 1'b0, 8'h03));
        wait_idle();
        dbg_chk(2'd0, 8'h00);

        // Backpressure with a pending instruction.
        bus.out_ready = 1'b0;
        put(enc(3'd0, 2'd3, 2'd3, 1'b1, 8'h01));
        bus.instr = enc(3'd3, 2'd1, 2'd3, 1'b1, 8'h40);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_result", bus.out_result, 8'h3D);
            chk("bp_ready", bus.instr_ready, 1'b0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_drain", bus.instr_ready, 1'b0);
        @(negedge clk);
        chk("bp_ready_idle", bus.instr_ready, 1'b1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk("bp_accepted", bus.instr_ready, 1'b0);
        wait_idle();
        dbg_chk(2'd1, 8'h7D);

        // Illegal opcode: no writeback.
        put(enc(3'b110, 2'd2, 2'd0, 1'b1, 8'h12));
        wait_idle();
        dbg_chk(2'd2, 8'h3C);

        // Back-to-back XOR chain on the same register.
        put(enc(3'd0, 2'd1, 2'd0, 1'b1, 8'hAA));
        wait_idle();
        @(posedge clk); #1;
        bus.instr = enc(3'd4, 2'd1, 2'd1, 1'b1, 8'hFF);
        bus.instr_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("b2b_slot", bus.instr_ready, 1'((i % 3) == 0));
            if (bus.instr_ready) acc++;
        end
        @(posedge clk); #1 bus.instr_valid = 1'b0;
        chk("b2b_count", acc, 3);
        wait_idle();
        dbg_chk(2'd1, 8'h55);
        chk("sb_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
